// File: rtl/fixed_log2_unit.sv
// fixed_log2_unit
// Iterative base-2 logarithm of an unsigned Q5.27 sample.
// The integer part comes from the leading-one position. The fraction is
// produced one bit per cycle by repeatedly squaring the mantissa, which is
// normalised to [1,2). The result leaves on a valid/ready handshake.

module fixed_log2_unit #(
  parameter int FRAC_BITS = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [31:0]            in_data,
  input  logic                   in_valid,
  output logic                   in_ready,
  output logic [FRAC_BITS+5:0]   out_log2,
  output logic                   out_zero,
  output logic                   out_valid,
  input  logic                   out_ready
);

  localparam int OUT_W = FRAC_BITS + 6;
  localparam int CNT_W = 5;

  // Index of the final squaring iteration.
  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(FRAC_BITS - 1);

  // Result reported for a zero input: the most negative value.
  localparam logic [OUT_W-1:0] MOST_NEG = {1'b1, {(OUT_W-1){1'b0}}};

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SQUARE = 2'd1,
    ST_DONE   = 2'd2
  } state_e;

  // Position of the most significant set bit. Returns 0 for a zero word;
  // the caller treats zero separately.
  function automatic logic [4:0] lead_one(input logic [31:0] v);
    logic [4:0] idx;
    idx = 5'd0;
    for (int i = 0; i < 32; i++) begin
      if (v[i]) begin
        idx = 5'(i);
      end
    end
    return idx;
  endfunction

  state_e               state_q;
  logic [31:0]          mant_q;
  logic [CNT_W-1:0]     cnt_q;
  logic                 in_ready_q;
  logic                 out_valid_q;
  logic                 out_zero_q;
  logic [OUT_W-1:0]     out_log2_q;

  logic [4:0]           lead_idx;
  logic [4:0]           shift_amt;
  logic [31:0]          norm_mant_d;
  logic [5:0]           int_part_d;
  logic [32:0]          sq_top;
  logic                 sq_bit;
  logic [31:0]          mant_sq_d;
  logic [FRAC_BITS-1:0] frac_d;

  // Leading-one detection and normalisation of the incoming sample.
  always_comb begin
    lead_idx    = lead_one(in_data);
    shift_amt   = 5'd31 - lead_idx;
    norm_mant_d = in_data << shift_amt;
    // A Q5.27 value with its leading one at bit p has integer log p-27.
    int_part_d  = {1'b0, lead_idx} - 6'd27;
  end

  // One squaring step. Bits [63:31] of the Q2.62 product are kept. A set
  // top bit means m*m >= 2, which emits a 1 and renormalises by halving.
  // Plain truncation, with no rounding.
  always_comb begin
    sq_top    = 33'((64'(mant_q) * 64'(mant_q)) >> 31);
    sq_bit    = sq_top[32];
    mant_sq_d = sq_bit ? sq_top[32:1] : sq_top[31:0];
    // Fraction bits enter at the LSB and move up. After FRAC_BITS steps the
    // first bit produced is in the fraction MSB.
    frac_d    = (out_log2_q[FRAC_BITS-1:0] << 1'b1) | FRAC_BITS'(sq_bit);
  end

  // Control FSM with registered handshake and result outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      mant_q      <= 32'd0;
      cnt_q       <= {CNT_W{1'b0}};
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      out_zero_q  <= 1'b0;
      out_log2_q  <= {OUT_W{1'b0}};
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (in_valid && in_ready_q) begin
            in_ready_q <= 1'b0;
            if (in_data == 32'd0) begin
              out_zero_q  <= 1'b1;
              out_log2_q  <= MOST_NEG;
              out_valid_q <= 1'b1;
              state_q     <= ST_DONE;
            end else begin
              out_zero_q  <= 1'b0;
              out_log2_q  <= {int_part_d, {FRAC_BITS{1'b0}}};
              mant_q      <= norm_mant_d;
              cnt_q       <= {CNT_W{1'b0}};
              state_q     <= ST_SQUARE;
            end
          end
        end
        ST_SQUARE: begin
          mant_q                     <= mant_sq_d;
          out_log2_q[FRAC_BITS-1:0]  <= frac_d;
          cnt_q                      <= cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
          if (cnt_q == LAST_ITER) begin
            out_valid_q <= 1'b1;
            state_q     <= ST_DONE;
          end
        end
        ST_DONE: begin
          // The accept path reopens only on the next cycle. This prevents
          // a result handshake and a new accept in the same cycle.
          if (out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= ST_IDLE;
          end
        end
        default: begin
          out_valid_q <= 1'b0;
          in_ready_q  <= 1'b1;
          state_q     <= ST_IDLE;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_zero  = out_zero_q;
  assign out_log2  = out_log2_q;

endmodule

// File: tb/tb_fixed_log2_unit.sv
// Directed-vector bench for fixed_log2_unit (FRAC_BITS = 16).

module tb_fixed_log2_unit;

  localparam int FB  = 16;
  localparam int OW  = FB + 6;
  localparam int LAT = FB;

  logic          clk;
  logic          rst_n;
  logic [31:0]   in_data;
  logic          in_valid;
  logic          in_ready;
  logic [OW-1:0] out_log2;
  logic          out_zero;
  logic          out_valid;
  logic          out_ready;

  int n_vec;
  int n_chk;
  int n_err;

  typedef struct {
    logic [31:0]   din;
    logic [OW-1:0] exp_log;
    logic          exp_zero;
    int            exp_lat;
  } vec_t;

  vec_t vecs[9];

  fixed_log2_unit #(.FRAC_BITS(FB)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_log2  (out_log2),
    .out_zero  (out_zero),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Watchdog so the run always ends.
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h required 0x%08h", name, act, exp);
    end
  endtask

  // Reference model: truncating repeated squaring of the normalised mantissa.
  function automatic logic [OW-1:0] model(input logic [31:0] d);
    int          p;
    logic [5:0]  ip;
    logic [31:0] m;
    logic [63:0] pr;
    logic [FB-1:0] f;
    if (d == 32'd0) begin
      return {1'b1, {(OW-1){1'b0}}};
    end
    p = 0;
    for (int i = 0; i < 32; i++) begin
      if (d[i]) p = i;
    end
    ip = 6'(p - 27);
    m  = d << (31 - p);
    f  = '0;
    for (int k = 0; k < FB; k++) begin
      pr = {32'd0, m} * {32'd0, m};
      if (pr[63]) begin
        f[FB-1-k] = 1'b1;
        m = pr[63:32];
      end else begin
        m = pr[62:31];
      end
    end
    return {ip, f};
  endfunction

  // Offer one sample and wait for the result. lat is the number of rising
  // edges after the accept edge at which out_valid is first seen.
  task automatic apply(input logic [31:0] d, input logic ordy, output int lat);
    int w;
    w = 0;
    @(negedge clk);
    while (!in_ready && w < 50) begin
      @(negedge clk);
      w++;
    end
    check("in_ready_idle", {31'd0, in_ready}, 32'd1);
    in_data   = d;
    in_valid  = 1'b1;
    out_ready = ordy;
    n_vec++;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_data  = 32'hDEAD_BEEF;
    lat = 0;
    while (!out_valid && lat < 100) begin
      @(posedge clk);
      #1;
      lat++;
    end
  endtask

  initial begin
    int lat;

    vecs[0] = '{32'h0800_0000, 22'h000000, 1'b0, LAT};  // 1.0
    vecs[1] = '{32'h8000_0000, 22'h040000, 1'b0, LAT};  // 16.0, p=31
    vecs[2] = '{32'h0000_0001, 22'h250000, 1'b0, LAT};  // 2^-27, p=0
    vecs[3] = '{32'h1800_0000, 22'h0195C0, 1'b0, LAT};  // 3.0
    vecs[4] = '{32'h0000_0000, 22'h200000, 1'b1, 0};    // zero
    vecs[5] = '{32'h0C00_0000, 22'h0095C0, 1'b0, LAT};  // 1.5
    vecs[6] = '{32'hFFFF_FFFF, 22'h04FFFF, 1'b0, LAT};  // just under 32
    vecs[7] = '{32'h0000_0003, 22'h2695C0, 1'b0, LAT};  // 3 * 2^-27
    vecs[8] = '{32'h1000_0000, 22'h010000, 1'b0, LAT};  // 2.0

    n_vec = 0; n_chk = 0; n_err = 0;
    rst_n = 1'b0; in_data = 32'd0; in_valid = 1'b0; out_ready = 1'b0;

    // Reset state.
    repeat (2) @(negedge clk);
    check("rst_in_ready",  {31'd0, in_ready},  32'd1);
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_out_zero",  {31'd0, out_zero},  32'd0);
    check("rst_out_log2",  32'(out_log2),      32'd0);
    rst_n = 1'b1;

    // Table of directed vectors, downstream always ready.
    for (int i = 0; i < 9; i++) begin
      apply(vecs[i].din, 1'b1, lat);
      check($sformatf("v%0d_latency", i), 32'(lat), 32'(vecs[i].exp_lat));
      check($sformatf("v%0d_log2", i), 32'(out_log2), 32'(vecs[i].exp_log));
      check($sformatf("v%0d_zero", i), {31'd0, out_zero}, {31'd0, vecs[i].exp_zero});
      check($sformatf("v%0d_model", i), 32'(out_log2), 32'(model(vecs[i].din)));
      @(posedge clk);
      #1;
      check($sformatf("v%0d_release", i), {30'd0, out_valid, in_ready}, 32'd1);
    end

    // Backpressure: hold the result in DONE and offer a sample meanwhile.
    apply(32'h1000_0000, 1'b0, lat);
    check("bp_latency", 32'(lat), 32'(LAT));
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      in_valid = 1'b1;
      in_data  = 32'h0800_0000;
      @(posedge clk);
      #1;
      check("bp_hold_log2", 32'(out_log2), 32'h0001_0000);
      check("bp_hold_valid_ready", {30'd0, out_valid, in_ready}, 32'd2);
    end
    @(negedge clk);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    check("bp_release", {30'd0, out_valid, in_ready}, 32'd1);
    for (int c = 0; c < 20; c++) begin
      @(posedge clk);
      #1;
      check("bp_no_accept", {31'd0, out_valid}, 32'd0);
    end

    // Reset during iteration 8 aborts the operation.
    @(negedge clk);
    in_data   = 32'h0800_0000;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    n_vec++;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (8) @(posedge clk);
    @(negedge clk);
    check("mid_busy", {30'd0, out_valid, in_ready}, 32'd0);
    rst_n = 1'b0;
    #1;
    check("mid_rst_in_ready",  {31'd0, in_ready},  32'd1);
    check("mid_rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("mid_rst_out_zero",  {31'd0, out_zero},  32'd0);
    check("mid_rst_out_log2",  32'(out_log2),      32'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    apply(32'h0800_0000, 1'b1, lat);
    check("post_rst_latency", 32'(lat), 32'(LAT));
    check("post_rst_log2", 32'(out_log2), 32'd0);
    check("post_rst_zero", {31'd0, out_zero}, 32'd0);
    @(posedge clk);
    #1;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
